rs_age_sched: RTL
=================

// Module: rs_age_sched
// PURPOSE
//  Next-generation reservation station: DEPTH-entry unified scheduler between dispatch and the FUs.
//  Oldest-first (age-matrix) selection per FU class, with per-slot FU ready handshake.
//  Same-cycle CDB capture on dispatch, and EBR squash/clear applied to entries, dispatch and issue.
// PARAMETERS
//  DEPTH      32             number of entries (>=2)
//  N          `N             dispatch width and CDB width
//  NUM_ALU    `NUM_FU_ALU    ALU issue slots (>=1); NUM_MULT/NUM_LD/NUM_STORE/NUM_BR likewise, default `NUM_FU_*
// PORTS
//  clock         in   1                        clock
//  reset         in   1                        reset, synchronous, active-high
//  rs_in         in   RS_PACKET[N]             dispatched instrs; .valid per lane
//  cdb_in        in   CDB_PACKET[N]            completing tags; .valid, .reg_idx
//  br_id         in   BR_MASK                  one-hot branch being resolved
//  br_task       in   BR_TASK                  NOTHING / CLEAR / SQUASH
//  alu_ready     in   NUM_ALU                  FU slot can accept this cycle (one per slot; mult/ld/store/br same)
//  issued_alu    out  RS_PACKET[NUM_ALU]       issue packet per slot, .valid qualifies (mult/ld/store/br same)
//  open_entries  out  $clog2(DEPTH+1)          free entries, registered count
// BEHAVIOUR
//  - Reset: all entries invalid, age matrix 0, open_entries=DEPTH, every issued_*.valid=0 (issue is comb from state).
//  - Entry state: RS_PACKET + older[i][j]; older[i][j]=1 means entry i was written before entry j.
//  - Request: req[i] = valid & t1.ready & t2.ready & ~squashed_now[i];
//    squashed_now[i] = (br_task==SQUASH) & |(b_mask & br_id).
//  - Rank[i] = popcount of req[j] with same fu_type and older[j][i]=1.
//    Entry is granted slot Rank[i] when Rank[i] < NUM_<class>.
//  - Slot s output = granted entry with .valid = alu_ready[s]; if CLEAR, output b_mask has br_id bit cleared.
//    Not-ready slot: output .valid=0 and the entry stays, retrying next cycle (oldest still first).
//  - Issued entry is invalidated at the edge.
//  - Issue latency: an entry dispatched at cycle t requests at t+1 earliest. A CDB tag at t wakes operands at the edge, so issue at t+1.
//  - Wakeup: for each cdb_in[k].valid, every valid entry with t1/t2.reg_idx==tag sets ready.
//    Multiple hits on the same tag are harmless.
//  - Dispatch: lanes consumed in lane order into the lowest-index free entries (free = invalid at cycle start).
//    Slots freed this cycle are not reused until next cycle.
//    CDB tags broadcast in the same cycle are applied to incoming t1/t2.
//    Older bits: new entry is younger than all resident entries.
//    Among same-cycle lanes, the lower lane is older.
//    Clear column/row of freed entries.
//  - Capacity: upstream presents <= open_entries valid lanes. Excess lanes are dropped and `ifdef DEBUG assertion fires.
//  - SQUASH: entries with b_mask&br_id !=0 invalidated; dispatching lanes matching br_id dropped; such entries never issue that cycle.
//  - CLEAR: b_mask ^= br_id on matching resident and dispatching entries.
//  - open_entries next = open_entries - accepted + issued + squashed; no double count when an entry is both issued and squashed (squash wins).
//  - Full: open_entries=0 -> all lanes ignored, issue continues. Empty: no req, all .valid=0.
//  - Reset mid-operation overrides all same-cycle dispatch, wakeup and squash.
// TESTING
//  1 reset; dispatch 1 ALU op, both ready, alu_ready=1 -> issued_alu[0].valid at next cycle; open_entries 32->31->32.
//  2 dispatch ALU ops A (cycle 0), B (cycle 1) both ready, NUM_ALU=1 -> A issues first, then B; with alu_ready=0 neither issues and A stays oldest.
//  3 op waiting on p5, CDB p5 same cycle as dispatch -> issues next cycle; CDB p5 one cycle later -> issues two cycles after dispatch.
//  4 entries masks 0b01/0b10/0b00, SQUASH br_id=0b01 while masked entry is ready -> not issued, open_entries+1; CLEAR 0b10 -> issued b_mask=0.
//  5 fill to 32, dispatch N more with one issue -> lanes dropped, open_entries 0->1; next cycle 1 lane accepted.

Source files
------------

// File: rtl/rs_age_sched_if.sv
// Scheduler bus bundle: dispatch lanes, CDB tags, branch resolution, and per-class FU issue slots.
// Issue handshake: issued_<class>[s] moves a packet exactly when its .valid is 1. That .valid already
// includes <class>_ready[s], so the FU takes the packet whenever valid is seen. A slot held off by
// ready=0 shows valid=0, and the entry retries on the next cycle.
interface rs_age_sched_if #(
  parameter int N         = 2,
  parameter int NUM_ALU   = 2,
  parameter int NUM_MULT  = 1,
  parameter int NUM_LD    = 1,
  parameter int NUM_STORE = 1,
  parameter int NUM_BR    = 1,
  parameter int RS_W      = 28,
  parameter int CDB_W     = 7,
  parameter int BR_W      = 4,
  parameter int CNT_W     = 6
);
  logic [N-1:0][RS_W-1:0]         rs_in;
  logic [N-1:0][CDB_W-1:0]        cdb_in;
  logic [BR_W-1:0]                br_id;
  logic [1:0]                     br_task;
  logic [NUM_ALU-1:0]             alu_ready;
  logic [NUM_MULT-1:0]            mult_ready;
  logic [NUM_LD-1:0]              ld_ready;
  logic [NUM_STORE-1:0]           store_ready;
  logic [NUM_BR-1:0]              br_ready;
  logic [NUM_ALU-1:0][RS_W-1:0]   issued_alu;
  logic [NUM_MULT-1:0][RS_W-1:0]  issued_mult;
  logic [NUM_LD-1:0][RS_W-1:0]    issued_ld;
  logic [NUM_STORE-1:0][RS_W-1:0] issued_store;
  logic [NUM_BR-1:0][RS_W-1:0]    issued_br;
  logic [CNT_W-1:0]               open_entries;

  modport master (
    output rs_in, cdb_in, br_id, br_task,
    output alu_ready, mult_ready, ld_ready, store_ready, br_ready,
    input  issued_alu, issued_mult, issued_ld, issued_store, issued_br, open_entries
  );
  modport slave (
    input  rs_in, cdb_in, br_id, br_task,
    input  alu_ready, mult_ready, ld_ready, store_ready, br_ready,
    output issued_alu, issued_mult, issued_ld, issued_store, issued_br, open_entries
  );
endinterface

// File: rtl/rs_age_sched.sv
// Unified reservation station: age-matrix oldest-first issue per FU class, dispatch-time CDB capture,
// and branch squash/clear applied to resident, dispatching and issuing entries.
package rs_age_pkg;
  localparam int N_LANES      = 2;
  localparam int NUM_FU_ALU   = 2;
  localparam int NUM_FU_MULT  = 1;
  localparam int NUM_FU_LD    = 1;
  localparam int NUM_FU_STORE = 1;
  localparam int NUM_FU_BR    = 1;
  localparam int TAG_W        = 6;
  localparam int BR_W         = 4;

  localparam logic [2:0] FU_ALU   = 3'd0;
  localparam logic [2:0] FU_MULT  = 3'd1;
  localparam logic [2:0] FU_LD    = 3'd2;
  localparam logic [2:0] FU_STORE = 3'd3;
  localparam logic [2:0] FU_BR    = 3'd4;

  typedef enum logic [1:0] {BR_NOTHING = 2'd0, BR_CLEAR = 2'd1, BR_SQUASH = 2'd2} br_task_t;

  typedef struct packed {
    logic [TAG_W-1:0] reg_idx;
    logic             ready;
  } operand_t;

  typedef struct packed {
    logic             valid;
    logic [2:0]       fu_type;
    logic [TAG_W-1:0] dest;
    operand_t         t1;
    operand_t         t2;
    logic [BR_W-1:0]  b_mask;
  } rs_packet_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] reg_idx;
  } cdb_packet_t;
endpackage

module rs_age_sched #(
  parameter int DEPTH     = 32,
  parameter int N         = rs_age_pkg::N_LANES,
  parameter int NUM_ALU   = rs_age_pkg::NUM_FU_ALU,
  parameter int NUM_MULT  = rs_age_pkg::NUM_FU_MULT,
  parameter int NUM_LD    = rs_age_pkg::NUM_FU_LD,
  parameter int NUM_STORE = rs_age_pkg::NUM_FU_STORE,
  parameter int NUM_BR    = rs_age_pkg::NUM_FU_BR
) (
  input  logic          clock,
  input  logic          reset,
  rs_age_sched_if.slave bus
);
  import rs_age_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NCLS  = 5;
  localparam int M1    = (NUM_ALU > NUM_MULT) ? NUM_ALU : NUM_MULT;
  localparam int M2    = (M1 > NUM_LD) ? M1 : NUM_LD;
  localparam int M3    = (M2 > NUM_STORE) ? M2 : NUM_STORE;
  localparam int MAXS  = (M3 > NUM_BR) ? M3 : NUM_BR;

  typedef logic [IDX_W:0]   rank_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int slots_of(input int c);
    case (c)
      0:       return NUM_ALU;
      1:       return NUM_MULT;
      2:       return NUM_LD;
      3:       return NUM_STORE;
      default: return NUM_BR;
    endcase
  endfunction

  function automatic rs_packet_t wake(input rs_packet_t p, input cdb_packet_t [N-1:0] tags);
    rs_packet_t w;
    w = p;
    for (int k = 0; k < N; k++) begin
      if (tags[k].valid) begin
        if (w.t1.reg_idx == tags[k].reg_idx) w.t1.ready = 1'b1;
        if (w.t2.reg_idx == tags[k].reg_idx) w.t2.ready = 1'b1;
      end
    end
    return w;
  endfunction

  rs_packet_t [DEPTH-1:0]         entry_q, entry_d;
  logic [DEPTH-1:0][DEPTH-1:0]    older_q, older_d;
  cnt_t                           open_q, open_d;

  rs_packet_t [N-1:0]             lanes;
  cdb_packet_t [N-1:0]            cdb;
  logic                           squash, clear;
  logic [DEPTH-1:0]               sq_now, req, issue_now, freed;
  rank_t [DEPTH-1:0]              rank;
  logic [NCLS-1:0][MAXS-1:0]      fu_ready;
  rs_packet_t [NCLS-1:0][MAXS-1:0] iss_pkt;
  logic [N-1:0]                   lane_ok;
  logic [N-1:0][IDX_W-1:0]        lane_idx;
  logic [DEPTH-1:0]               taken;
  cnt_t                           accepted, freed_cnt;

  always_comb begin
    squash = (bus.br_task == BR_SQUASH);
    clear  = (bus.br_task == BR_CLEAR);
    for (int l = 0; l < N; l++) begin
      lanes[l] = bus.rs_in[l];
      cdb[l]   = bus.cdb_in[l];
    end
    fu_ready = '0;
    fu_ready[0][NUM_ALU-1:0]   = bus.alu_ready;
    fu_ready[1][NUM_MULT-1:0]  = bus.mult_ready;
    fu_ready[2][NUM_LD-1:0]    = bus.ld_ready;
    fu_ready[3][NUM_STORE-1:0] = bus.store_ready;
    fu_ready[4][NUM_BR-1:0]    = bus.br_ready;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sq_now[i] = squash & entry_q[i].valid & (|(entry_q[i].b_mask & bus.br_id));
      req[i]    = entry_q[i].valid & entry_q[i].t1.ready & entry_q[i].t2.ready & ~sq_now[i];
    end
  end

  // Rank = number of older requesters in the same class; it picks the slot an entry lands in.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rank[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (req[j] && (entry_q[j].fu_type == entry_q[i].fu_type) && older_q[j][i])
          rank[i] = rank[i] + rank_t'(1);
      end
    end
  end

  always_comb begin
    iss_pkt   = '0;
    issue_now = '0;
    for (int c = 0; c < NCLS; c++) begin
      for (int s = 0; s < MAXS; s++) begin
        if (s < slots_of(c)) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && (entry_q[i].fu_type == 3'(c)) && (rank[i] == rank_t'(s))) begin
              iss_pkt[c][s]       = entry_q[i];
              iss_pkt[c][s].valid = fu_ready[c][s];
              if (clear) iss_pkt[c][s].b_mask = entry_q[i].b_mask & ~bus.br_id;
              issue_now[i]        = fu_ready[c][s];
            end
          end
        end
      end
    end
  end

  for (genvar s = 0; s < NUM_ALU; s++) begin : g_alu
    assign bus.issued_alu[s] = iss_pkt[0][s];
  end
  for (genvar s = 0; s < NUM_MULT; s++) begin : g_mult
    assign bus.issued_mult[s] = iss_pkt[1][s];
  end
  for (genvar s = 0; s < NUM_LD; s++) begin : g_ld
    assign bus.issued_ld[s] = iss_pkt[2][s];
  end
  for (genvar s = 0; s < NUM_STORE; s++) begin : g_store
    assign bus.issued_store[s] = iss_pkt[3][s];
  end
  for (genvar s = 0; s < NUM_BR; s++) begin : g_br
    assign bus.issued_br[s] = iss_pkt[4][s];
  end
  assign bus.open_entries = open_q;

  always_comb begin
    entry_d   = entry_q;
    older_d   = older_q;
    freed     = issue_now | sq_now;
    freed_cnt = '0;
    accepted  = '0;
    taken     = '0;
    lane_ok   = '0;
    lane_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = wake(entry_q[i], cdb);
      if (clear) entry_d[i].b_mask = entry_q[i].b_mask & ~bus.br_id;
      if (freed[i]) begin
        entry_d[i].valid = 1'b0;
        freed_cnt        = freed_cnt + cnt_t'(1);
        for (int j = 0; j < DEPTH; j++) begin
          older_d[i][j] = 1'b0;
          older_d[j][i] = 1'b0;
        end
      end
    end
    // Only slots invalid at cycle start are candidates, so a slot freed this cycle waits one cycle.
    for (int l = 0; l < N; l++) begin
      if (lanes[l].valid && !(squash && (|(lanes[l].b_mask & bus.br_id)))) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!lane_ok[l] && !entry_q[i].valid && !taken[i]) begin
            lane_ok[l]  = 1'b1;
            lane_idx[l] = IDX_W'(i);
            taken[i]    = 1'b1;
          end
        end
      end
    end
    for (int l = 0; l < N; l++) begin
      if (lane_ok[l]) begin
        accepted = accepted + cnt_t'(1);
        entry_d[lane_idx[l]]       = wake(lanes[l], cdb);
        entry_d[lane_idx[l]].valid = 1'b1;
        if (clear) entry_d[lane_idx[l]].b_mask = lanes[l].b_mask & ~bus.br_id;
        for (int j = 0; j < DEPTH; j++) begin
          older_d[lane_idx[l]][j] = 1'b0;
          older_d[j][lane_idx[l]] = entry_q[j].valid & ~freed[j];
        end
        for (int m = 0; m < l; m++) begin
          if (lane_ok[m]) older_d[lane_idx[m]][lane_idx[l]] = 1'b1;
        end
      end
    end
    open_d = open_q - accepted + freed_cnt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= '0;
      older_q <= '0;
      open_q  <= cnt_t'(DEPTH);
    end else begin
      entry_q <= entry_d;
      older_q <= older_d;
      open_q  <= open_d;
    end
  end

`ifdef DEBUG
  cnt_t lanes_want;
  always_comb begin
    lanes_want = '0;
    for (int l = 0; l < N; l++) begin
      if (lanes[l].valid && !(squash && (|(lanes[l].b_mask & bus.br_id))))
        lanes_want = lanes_want + cnt_t'(1);
    end
  end
  a_no_overflow: assert property (@(posedge clock) disable iff (reset) lanes_want <= open_q);
`endif
endmodule
